// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared types and sizing helpers for the restoring divider
//
// Contents:
//   state_t            FSM state encoding (S_IDLE, S_RUN, S_DONE), 2 bits
//   DEFAULT_WIDTH      default factor width
//   step_cnt_width()   width of the step counter for a given factor width

package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must hold 0..WIDTH so the final step index is representable.
    function automatic int step_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step_cell.sv
// rtl/seq_restoring_divider_div_step_cell.sv - one restoring-division step (trial subtract + restore)
//
// Ports:
//   t        in   WIDTH+1  shifted partial remainder {P[W-1:0], next dividend bit}
//   divisor  in   WIDTH    divisor
//   p_next   out  WIDTH+1  next partial remainder (difference, or t restored)
//   qbit     out  1        quotient bit produced by this step

module div_step_cell #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_next,
    output logic             qbit
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff   = t - {1'b0, divisor};
        // No borrow means the trial subtraction is kept; otherwise restore t.
        qbit   = (t >= {1'b0, divisor});
        p_next = qbit ? diff : t;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential restoring divider, one quotient bit per clock
//
// Ports:
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous active-high reset
//   start        in   1        divide request, sampled only in IDLE
//   dividend     in   2*WIDTH  dividend, captured on accepted start
//   divisor      in   WIDTH    divisor, captured on accepted start
//   busy         out  1        high in RUN and DONE
//   done         out  1        single-cycle pulse, results valid from this cycle on
//   quotient     out  WIDTH    quotient, held until next accepted start completes
//   remainder    out  WIDTH    remainder, held likewise
//   div_by_zero  out  1        last accepted divisor was zero
//   overflow     out  1        last accepted quotient would not fit in WIDTH bits

module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = step_cnt_width(WIDTH);

    state_t state, state_next;

    logic [CW-1:0]    step;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] lo_sr;      // remaining low dividend bits, MSB consumed first
    logic [WIDTH-2:0] q_sr;       // quotient bits gathered so far
    logic [WIDTH-1:0] p_reg;      // partial remainder; always < divisor so W bits suffice

    logic [WIDTH-1:0] dvd_hi;
    logic [WIDTH-1:0] dvd_lo;
    logic             is_zero;
    logic             is_ovf;
    logic             accept;
    logic             last_step;

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   p_next;
    logic             qbit;
    logic [WIDTH-1:0] q_next;
    logic             unused_p_msb;

    assign dvd_hi    = dividend[2*WIDTH-1:WIDTH];
    assign dvd_lo    = dividend[WIDTH-1:0];
    assign is_zero   = (divisor == '0);
    assign is_ovf    = (dvd_hi >= divisor);
    assign accept    = (state == S_IDLE) && start;
    assign last_step = (step == CW'(WIDTH - 1));

    assign t      = {p_reg, lo_sr[WIDTH-1]};
    assign q_next = {q_sr, qbit};
    // The precheck keeps P below the divisor, so the top bit of the step result is always 0.
    assign unused_p_msb = p_next[WIDTH];

    div_step_cell #(
        .WIDTH(WIDTH)
    ) u_step (
        .t       (t),
        .divisor (divisor_q),
        .p_next  (p_next),
        .qbit    (qbit)
    );

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (is_zero || is_ovf) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step        <= '0;
            divisor_q   <= '0;
            lo_sr       <= '0;
            q_sr        <= '0;
            p_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            divisor_q   <= divisor;
            lo_sr       <= dvd_lo;
            p_reg       <= dvd_hi;
            q_sr        <= '0;
            step        <= '0;
            div_by_zero <= is_zero;
            overflow    <= !is_zero && is_ovf;
            // Degenerate cases finish immediately, so their results land now.
            if (is_zero || is_ovf) begin
                quotient  <= '1;
                remainder <= dvd_lo;
            end
        end else if (state == S_RUN) begin
            p_reg <= p_next[WIDTH-1:0];
            lo_sr <= {lo_sr[WIDTH-2:0], 1'b0};
            q_sr  <= q_next[WIDTH-2:0];
            step  <= step + CW'(1);
            if (last_step) begin
                quotient  <= q_next;
                remainder <= p_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider (WIDTH=4)

module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   dividend = '0;
    logic [3:0]   divisor = '0;
    logic         busy;
    logic         done;
    logic [3:0]   quotient;
    logic [3:0]   remainder;
    logic         div_by_zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, with the out-of-range cases the block defines.
    task automatic model(input int dvd, input int dvs,
                         output int q, output int r, output int dbz, output int ovf, output int lat);
        dbz = 0; ovf = 0;
        if (dvs == 0) begin
            dbz = 1; q = 15; r = dvd % 16; lat = 1;
        end else if (dvd / dvs > 15) begin
            ovf = 1; q = 15; r = dvd % 16; lat = 1;
        end else begin
            q = dvd / dvs; r = dvd % dvs; lat = W + 1;
        end
    endtask

    task automatic check_results(input string tag, input int dvd, input int dvs);
        int q, r, dbz, ovf, lat;
        model(dvd, dvs, q, r, dbz, ovf, lat);
        check({tag, "_q"}, quotient, q);
        check({tag, "_r"}, remainder, r);
        check({tag, "_dbz"}, div_by_zero, dbz);
        check({tag, "_ovf"}, overflow, ovf);
    endtask

    // Issues one divide, measures latency in edges from the accepting edge (inclusive).
    task automatic run_div(input string tag, input int dvd, input int dvs);
        int q, r, dbz, ovf, lat, n;
        model(dvd, dvs, q, r, dbz, ovf, lat);
        @(negedge clk);
        start = 1'b1; dividend = dvd[7:0]; divisor = dvs[3:0];
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check_results(tag, dvd, dvs);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_hold_q"}, quotient, q);
        check({tag, "_hold_r"}, remainder, r);
    endtask

    initial begin
        int dir_dvd [11] = '{70, 126, 225, 65, 121, 71, 12, 0, 45, 130, 112};
        int dir_dvs [11] = '{ 7,  14,  15, 13,  11,  7,  4, 12, 0,   7,   7};
        int last, cnt, prev, dvs, dvd, n;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_div($sformatf("dir%0d", i), dir_dvd[i], dir_dvs[i]);
        end

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                dvd = $urandom_range(0, 255);
                dvs = $urandom_range(0, 15);
            end else begin
                dvs = $urandom_range(1, 15);
                dvd = $urandom_range(0, 15) * dvs + $urandom_range(0, dvs - 1);
            end
            run_div($sformatf("rnd%0d", i), dvd, dvs);
        end

        // start pulsed in the middle of RUN must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd70; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd130; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ign_lat", n, W + 1);
        check_results("ign", 70, 7);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("ign_extra_done", cnt, 0);

        // start held high: back-to-back divides, one-cycle done each
        @(negedge clk);
        start = 1'b1; dividend = 8'd126; divisor = 4'd14;
        last = -1; cnt = 0; prev = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                check("b2b_single", prev, 0);
                if (last < 0) check("b2b_first", k, W + 1);
                else          check("b2b_gap", k - last, W + 2);
                check_results("b2b", 126, 14);
                last = k;
            end
            prev = done;
        end
        check("b2b_count", cnt, 3);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", busy, 0);

        // reset in the 2nd RUN cycle aborts the divide
        @(negedge clk);
        start = 1'b1; dividend = 8'd70; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        check("arst_dbz", div_by_zero, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        run_div("post_rst", 225, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
